weight_dispatch: RTL and testbench

WEIGHT_DISPATCH -- requirements
Module: weight_dispatch

---
 rtl/dnn_pkg.sv | 8 +
 rtl/sm_zero_detect.sv | 9 +
 rtl/weight_dispatch.sv | 127 ++++++++++++
 tb/tb_weight_dispatch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared widths and the dispatch state encoding for the weight dispatcher.
package dnn_pkg;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {IDLE, READ, CHECK, HOLD, DONE} dispatch_state_t;
endpackage

// File: rtl/sm_zero_detect.sv
// Sign-magnitude zero test: +0 and -0 both count as zero.
module sm_zero_detect
  import dnn_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              is_zero
);
  assign is_zero = (word[WORD_W-2:0] == '0);
endmodule

// File: rtl/weight_dispatch.sv
// Walks one weight row, reads each element and pushes only nonzero weights
// (with their row offset) into the PU buffer, stalling while the buffer is full.
//
// state | meaning
// IDLE  | waiting for start
// READ  | read strobe out for element idx
// CHECK | weight on w_data; skip, push, or park it if buffer full
// HOLD  | parked nonzero weight waiting for buffer space
// DONE  | done pulse, back to IDLE next cycle
module weight_dispatch
  import dnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [IDX_W-1:0]  row_length,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_data,
  output logic              fifo_w_en,
  output logic [WORD_W-1:0] fifo_data,
  output logic [IDX_W-1:0]  fifo_index,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    nnz_count
);
  dispatch_state_t state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [IDX_W-1:0]  len_q, len_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic [WORD_W-1:0] hold_q, hold_nxt;
  logic [IDX_W:0]    nnz_nxt;
  logic [WORD_W-1:0] push_data;
  logic              push, advance, is_zero;

  sm_zero_detect u_zero (
    .word    (w_data),
    .is_zero (is_zero)
  );

  always_comb begin
    state_nxt = state;
    base_nxt  = base_q;
    len_nxt   = len_q;
    idx_nxt   = idx_q;
    hold_nxt  = hold_q;
    nnz_nxt   = nnz_count;
    push_data = hold_q;
    push      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          base_nxt  = row_base;
          len_nxt   = row_length;
          idx_nxt   = '0;
          nnz_nxt   = '0;
          state_nxt = (row_length == '0) ? DONE : READ;
        end
      end
      READ: state_nxt = CHECK;
      CHECK: begin
        if (is_zero) begin
          advance = 1'b1;
        end else if (!fifo_full) begin
          push      = 1'b1;
          push_data = w_data;
          advance   = 1'b1;
        end else begin
          hold_nxt  = w_data;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!fifo_full) begin
          push    = 1'b1;
          advance = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (push) nnz_nxt = nnz_count + 1'b1;
    if (advance) begin
      idx_nxt   = idx_q + 1'b1;
      state_nxt = (idx_q == len_q - 1'b1) ? DONE : READ;
    end
  end

  // Strobes and status are registered from the next state, so each lines up
  // with the cycle the FSM actually spends in READ / DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      w_rd_en    <= 1'b0;
      w_addr     <= '0;
      fifo_w_en  <= 1'b0;
      fifo_data  <= '0;
      fifo_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nnz_count  <= '0;
    end else begin
      state     <= state_nxt;
      base_q    <= base_nxt;
      len_q     <= len_nxt;
      idx_q     <= idx_nxt;
      hold_q    <= hold_nxt;
      nnz_count <= nnz_nxt;
      w_rd_en   <= (state_nxt == READ);
      if (state_nxt == READ) w_addr <= base_nxt + ADDR_W'(idx_nxt);
      fifo_w_en <= push;
      if (push) begin
        fifo_data  <= push_data;
        fifo_index <= idx_q;
      end
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end
endmodule

// File: tb/tb_weight_dispatch.sv
// Self-checking bench for weight_dispatch: directed rows plus randomized rows
// compared against a list-level model of which weights get pushed.
module tb_weight_dispatch;
  typedef logic [31:0] q32_t[$];

  logic        clk = 1'b0;
  logic        rst, start, fifo_full;
  logic [9:0]  row_base, w_addr;
  logic [3:0]  row_length, fifo_index;
  logic        w_rd_en, fifo_w_en, busy, done;
  logic [15:0] w_data, fifo_data;
  logic [4:0]  nnz_count;

  weight_dispatch dut (
    .clk(clk), .rst(rst), .start(start), .row_base(row_base), .row_length(row_length),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .fifo_index(fifo_index), .fifo_full(fifo_full),
    .busy(busy), .done(done), .nnz_count(nnz_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  always @(posedge clk) if (w_rd_en) w_data <= mem[w_addr];

  int cyc = 0;
  int c0 = 0;
  int full_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: never full, 1: random (never while a push is on the bus), 2: window k=1..5, 3: always full
  always @(posedge clk) begin
    #1;
    case (full_mode)
      0: fifo_full = 1'b0;
      1: fifo_full = fifo_w_en ? 1'b0 : 1'($urandom_range(0, 1));
      2: fifo_full = ((cyc - c0) >= 1) && ((cyc - c0) <= 5);
      default: fifo_full = 1'b1;
    endcase
  end

  q32_t rd_q, rd_k, push_q, push_k, exp_rd, exp_push;
  int done_cnt, done_k, viol;
  int checks = 0;
  int passed = 0;

  always @(negedge clk) begin
    if (w_rd_en === 1'b1) begin
      rd_q.push_back(32'(w_addr));
      rd_k.push_back(32'(cyc - c0));
    end
    if (fifo_w_en === 1'b1) begin
      push_q.push_back({12'b0, fifo_data, fifo_index});
      push_k.push_back(32'(cyc - c0));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_k = cyc - c0;
    end
    if (fifo_w_en === 1'b1 && fifo_full === 1'b1) viol++;
  end

  function automatic bit q_eq(q32_t a, q32_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_mon();
    rd_q.delete(); rd_k.delete(); push_q.delete(); push_k.delete();
    done_cnt = 0; done_k = -1; viol = 0;
  endtask

  // Expected reads and pushes for a row, straight from the row contents.
  task automatic build_model(input logic [9:0] base, input logic [3:0] len);
    logic [9:0] a;
    exp_rd.delete(); exp_push.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = base + 10'(i);
      exp_rd.push_back(32'(a));
      if (mem[a][14:0] != 15'd0) exp_push.push_back({12'b0, mem[a], 4'(i)});
    end
  endtask

  task automatic dispatch(input logic [9:0] base, input logic [3:0] len, input int glitch_k,
                          input logic [9:0] gb, input logic [3:0] gl,
                          output bit tmo, output logic busy_after);
    clear_mon();
    @(posedge clk); #1;
    c0 = cyc + 1;
    row_base = base; row_length = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; row_base = 10'($urandom); row_length = 4'($urandom);
    tmo = 1'b1; busy_after = 1'bx;
    for (int i = 0; i < 400; i++) begin
      if ((cyc - c0) == glitch_k) begin
        start = 1'b1; row_base = gb; row_length = gl;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt > 0) begin
        tmo = 1'b0; busy_after = busy;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; row_base = 10'd5; row_length = 4'd3; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_rd_en, w_addr, fifo_w_en, fifo_data, fifo_index, busy, done, nnz_count} !== '0)
      $display("FAIL reset_outputs: got rd=%b addr=%h wen=%b data=%h idx=%h busy=%b done=%b nnz=%0d, want all 0",
               w_rd_en, w_addr, fifo_w_en, fifo_data, fifo_index, busy, done, nnz_count);
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, w_rd_en} !== 2'b00)
      $display("FAIL start_during_rst: got busy=%b rd=%b, want 0 0", busy, w_rd_en);
    else passed++;
  endtask

  task automatic test_basic_row();
    bit tmo; logic ba;
    q32_t want_pk = '{2, 6};
    q32_t want_rk = '{0, 2, 4, 6};
    mem[0] = 16'h0001; mem[1] = 16'h0000; mem[2] = 16'h0003; mem[3] = 16'h8000;
    full_mode = 0;
    build_model(10'd0, 4'd4);
    dispatch(10'd0, 4'd4, -1, '0, '0, tmo, ba);
    checks++;
    if (tmo) $display("FAIL basic_timeout: no done within bound");
    else passed++;
    checks++;
    if (!q_eq(push_q, exp_push)) $display("FAIL basic_pushes: got %p want %p", push_q, exp_push);
    else passed++;
    checks++;
    if (!q_eq(push_k, want_pk)) $display("FAIL basic_push_times: got %p want %p", push_k, want_pk);
    else passed++;
    checks++;
    if (!q_eq(rd_k, want_rk)) $display("FAIL basic_read_times: got %p want %p", rd_k, want_rk);
    else passed++;
    checks++;
    if (done_k != 8 || done_cnt != 1)
      $display("FAIL basic_done: got k=%0d count=%0d want k=8 count=1", done_k, done_cnt);
    else passed++;
    checks++;
    if (nnz_count !== 5'd2) $display("FAIL basic_nnz: got %0d want 2", nnz_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit tmo; logic ba;
    int first_free = 1 + 5;
    q32_t want_pk, want_rk;
    want_pk = '{first_free + 1, first_free + 5};
    want_rk = '{0, first_free + 1, first_free + 3, first_free + 5};
    full_mode = 2;
    build_model(10'd0, 4'd4);
    dispatch(10'd0, 4'd4, -1, '0, '0, tmo, ba);
    full_mode = 0;
    checks++;
    if (!q_eq(push_q, exp_push)) $display("FAIL bp_pushes: got %p want %p", push_q, exp_push);
    else passed++;
    checks++;
    if (!q_eq(push_k, want_pk)) $display("FAIL bp_push_times: got %p want %p", push_k, want_pk);
    else passed++;
    checks++;
    if (!q_eq(rd_k, want_rk)) $display("FAIL bp_read_times: got %p want %p", rd_k, want_rk);
    else passed++;
    checks++;
    if (viol != 0) $display("FAIL bp_push_while_full: got %0d want 0", viol);
    else passed++;
    checks++;
    if (tmo || done_k != first_free + 7 || nnz_count !== 5'd2)
      $display("FAIL bp_done: got tmo=%0d k=%0d nnz=%0d want k=%0d nnz=2", tmo, done_k, nnz_count, first_free + 7);
    else passed++;
  endtask

  task automatic test_zero_length();
    bit tmo; logic ba;
    dispatch(10'd77, 4'd0, -1, '0, '0, tmo, ba);
    checks++;
    if (tmo || done_k < 0 || done_k > 1 || done_cnt != 1)
      $display("FAIL zero_len_done: got tmo=%0d k=%0d count=%0d want k<=1 count=1", tmo, done_k, done_cnt);
    else passed++;
    checks++;
    if (rd_q.size() != 0 || nnz_count !== 5'd0 || ba !== 1'b0)
      $display("FAIL zero_len_quiet: got reads=%0d nnz=%0d busy=%b want 0 0 0", rd_q.size(), nnz_count, ba);
    else passed++;
  endtask

  task automatic test_wrap();
    bit tmo; logic ba;
    q32_t want_rd = '{32'h3FF, 32'h000};
    mem[10'h3FF] = 16'h1111; mem[10'h000] = 16'h8002;
    build_model(10'h3FF, 4'd2);
    dispatch(10'h3FF, 4'd2, -1, '0, '0, tmo, ba);
    checks++;
    if (!q_eq(rd_q, want_rd)) $display("FAIL wrap_reads: got %p want %p", rd_q, want_rd);
    else passed++;
    checks++;
    if (tmo || !q_eq(push_q, exp_push)) $display("FAIL wrap_pushes: got %p want %p", push_q, exp_push);
    else passed++;
  endtask

  task automatic test_reset_in_hold();
    bit tmo; logic ba;
    mem[40] = 16'h00A5; mem[41] = 16'h0000; mem[42] = 16'h8001;
    clear_mon();
    full_mode = 3;
    @(posedge clk); #1;
    c0 = cyc + 1; row_base = 10'd40; row_length = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || w_rd_en !== 1'b0 || push_q.size() != 0)
      $display("FAIL hold_stall: got busy=%b rd=%b pushes=%0d want 1 0 0", busy, w_rd_en, push_q.size());
    else passed++;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; full_mode = 0;
    @(negedge clk);
    checks++;
    if ({w_rd_en, w_addr, fifo_w_en, fifo_data, fifo_index, busy, done, nnz_count} !== '0)
      $display("FAIL hold_reset_outputs: got rd=%b addr=%h wen=%b data=%h idx=%h busy=%b done=%b nnz=%0d, want all 0",
               w_rd_en, w_addr, fifo_w_en, fifo_data, fifo_index, busy, done, nnz_count);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (push_q.size() != 0 || busy !== 1'b0)
      $display("FAIL hold_word_dropped: got pushes=%0d busy=%b want 0 0", push_q.size(), busy);
    else passed++;
    build_model(10'd40, 4'd3);
    dispatch(10'd40, 4'd3, -1, '0, '0, tmo, ba);
    checks++;
    if (tmo || !q_eq(push_q, exp_push) || nnz_count !== 5'(exp_push.size()))
      $display("FAIL after_reset_row: got %p nnz=%0d want %p nnz=%0d", push_q, nnz_count, exp_push, exp_push.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit tmo; logic ba;
    logic [9:0] base = 10'd200;
    for (int i = 0; i < 6; i++) mem[200 + i] = (i % 2 == 0) ? 16'(i + 1) : 16'h8000;
    full_mode = 0;
    build_model(base, 4'd6);
    dispatch(base, 4'd6, 3, base + 10'd100, 4'd2, tmo, ba);
    checks++;
    if (!q_eq(rd_q, exp_rd)) $display("FAIL b2b_reads: got %p want %p", rd_q, exp_rd);
    else passed++;
    checks++;
    if (!q_eq(push_q, exp_push)) $display("FAIL b2b_pushes: got %p want %p", push_q, exp_push);
    else passed++;
    checks++;
    if (tmo || done_cnt != 1 || ba !== 1'b0)
      $display("FAIL b2b_done: got tmo=%0d count=%0d busy_after=%b want 0 1 0", tmo, done_cnt, ba);
    else passed++;
    checks++;
    if (nnz_count !== 5'(exp_push.size()))
      $display("FAIL b2b_nnz: got %0d want %0d", nnz_count, exp_push.size());
    else passed++;
  endtask

  task automatic test_random_rows();
    bit tmo; logic ba;
    logic [9:0] base;
    logic [3:0] len;
    for (int i = 0; i < 1024; i++) begin
      case ($urandom_range(0, 2))
        0: mem[i] = 16'h0000;
        1: mem[i] = 16'h8000;
        default: mem[i] = 16'($urandom);
      endcase
    end
    full_mode = 1;
    for (int r = 0; r < 25; r++) begin
      base = 10'($urandom);
      len = 4'($urandom);
      build_model(base, len);
      dispatch(base, len, -1, '0, '0, tmo, ba);
      checks++;
      if (tmo || done_cnt != 1 || ba !== 1'b0)
        $display("FAIL rnd%0d_done: got tmo=%0d count=%0d busy_after=%b want 0 1 0", r, tmo, done_cnt, ba);
      else passed++;
      checks++;
      if (!q_eq(rd_q, exp_rd)) $display("FAIL rnd%0d_reads: got %p want %p", r, rd_q, exp_rd);
      else passed++;
      checks++;
      if (!q_eq(push_q, exp_push)) $display("FAIL rnd%0d_pushes: got %p want %p", r, push_q, exp_push);
      else passed++;
      checks++;
      if (nnz_count !== 5'(exp_push.size()))
        $display("FAIL rnd%0d_nnz: got %0d want %0d", r, nnz_count, exp_push.size());
      else passed++;
      checks++;
      if (viol != 0) $display("FAIL rnd%0d_push_while_full: got %0d want 0", r, viol);
      else passed++;
    end
    full_mode = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_base = '0; row_length = '0; fifo_full = 1'b0;
    clear_mon();
    test_reset();
    test_basic_row();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_reset_in_hold();
    test_back_to_back();
    test_random_rows();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
